// File: rtl/counter_0_7_if.sv
// counter_0_7_if: carries the count from the timing counter to upstream logic
//   non_recycling_counter_output  current count, 0..MAX_CNT
//   master: driven by the counter; slave: observed by consumers
interface counter_0_7_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] non_recycling_counter_output;
  modport master (output non_recycling_counter_output);
  modport slave  (input  non_recycling_counter_output);
endinterface

// File: rtl/counter_0_7.sv
// counter_0_7: non-recycling up-counter that saturates at MAX_CNT until cleared
//   clock   rising-edge system clock
//   clear   asynchronous active-low reset, forces the count to 0 at once
//   cnt_if  master side of counter_0_7_if, presents the registered count
module counter_0_7 #(
  parameter int WIDTH   = 3,
  parameter int MAX_CNT = 7
) (
  input  logic          clock,
  input  logic          clear,
  counter_0_7_if.master cnt_if
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_CNT);
  logic [WIDTH-1:0] cnt;
  always_ff @(posedge clock or negedge clear)
    if (!clear) cnt <= '0;
    else cnt <= (cnt == MAX_V) ? cnt : cnt + 1'b1;
  assign cnt_if.non_recycling_counter_output = cnt;
endmodule

// File: tb/tb_counter_0_7.sv
// tb_counter_0_7: scoreboard bench; expected count derived from edges since last clear
module tb_counter_0_7;
  localparam int WIDTH   = 3;
  localparam int MAX_CNT = 7;
  logic clock;
  logic clear;
  counter_0_7_if #(.WIDTH(WIDTH)) cnt_if ();
  counter_0_7 #(.WIDTH(WIDTH), .MAX_CNT(MAX_CNT)) dut (
    .clock (clock),
    .clear (clear),
    .cnt_if(cnt_if)
  );
  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned exp_q[$];
  string       tag_q[$];
  int          edges = 0;
  initial clock = 1'b0;
  always #5 clock = ~clock;
  // Monitor: the count is always presented, so compare once per cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        int unsigned e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (cnt_if.non_recycling_counter_output === WIDTH'(e)) passes++;
        else $display("FAIL %s: got %0d expected %0d", t,
                      cnt_if.non_recycling_counter_output, e);
      end
    end
  end
  // mode 0: run (clear high), 1: hold clear low, 2: short clear pulse between edges,
  // 3: release clear coincident with the rising edge
  task automatic step(input int mode, input string tag);
    @(posedge clock);
    edges = (clear === 1'b0) ? 0 : edges + 1;
    if (edges > 1000) edges = 1000;
    if (mode == 3) clear <= 1'b1;
    #1;
    if (mode == 0) clear = 1'b1;
    else if (mode == 1) begin
      clear = 1'b0;
      edges = 0;
    end else if (mode == 2) begin
      clear = 1'b0;
      #2 clear = 1'b1;
      edges = 0;
    end
    exp_q.push_back((edges > MAX_CNT) ? MAX_CNT : edges);
    tag_q.push_back(tag);
  endtask
  initial begin
    clear = 1'b0;
    #2;
    checks++;
    if (cnt_if.non_recycling_counter_output === '0) passes++;
    else $display("FAIL reset_state: got %0d expected 0", cnt_if.non_recycling_counter_output);
    for (int i = 0; i < 3; i++) step(1, "held_in_clear");
    for (int i = 0; i < 11; i++) step(0, "count_and_saturate");
    step(2, "pulse_clear_at_7");
    for (int i = 0; i < 3; i++) step(0, "count_after_pulse");
    step(1, "clear_mid_count");
    step(3, "release_on_edge");
    for (int i = 0; i < 3; i++) step(0, "count_after_edge_release");
    for (int i = 0; i < 200; i++) begin
      int r;
      int m;
      r = int'($urandom_range(0, 99));
      m = (r < 70) ? 0 : (r < 80) ? 1 : (r < 90) ? 2 : 3;
      if (m == 3 && clear !== 1'b0) m = 0;
      step(m, "random");
    end
    repeat (3) @(posedge clock);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
